// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 8-bit ALU: command FIFO, registered ALU drive,
// result capture and valid/ready presentation downstream.
module alu_cmd_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [WIDTH-1:0]           cmd_x,
  input  logic [WIDTH-1:0]           cmd_y,
  input  logic [2:0]                 cmd_op,
  output logic [WIDTH-1:0]           alu_x,
  output logic [WIDTH-1:0]           alu_y,
  output logic                       alu_s2,
  output logic                       alu_s1,
  output logic                       alu_s0,
  input  logic [WIDTH-1:0]           alu_z,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [WIDTH-1:0]           res_data,
  output logic [2:0]                 res_op,
  output logic                       res_err,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    RESULT
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] mem_x  [DEPTH];
  logic [WIDTH-1:0] mem_y  [DEPTH];
  logic [2:0]       mem_op [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;

  logic push, pop, capture, release_res;
  logic unsup;

  assign cmd_ready = (count_q != CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign count     = count_q;
  assign unsup     = alu_s2 & alu_s1;

  // Command storage; flushing is done through the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_x[wr_ptr]  <= cmd_x;
      mem_y[wr_ptr]  <= cmd_y;
      mem_op[wr_ptr] <= cmd_op;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and pop/capture/release strobes; occupancy is the
  // registered count, so a command written this edge waits one cycle.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        capture = 1'b1;
        state_d = RESULT;
      end
      RESULT: begin
        if (res_ready) begin
          release_res = 1'b1;
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = DRIVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU operand registers; they only change on a pop and hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_x  <= '0;
      alu_y  <= '0;
      alu_s2 <= 1'b0;
      alu_s1 <= 1'b0;
      alu_s0 <= 1'b0;
    end else if (pop) begin
      alu_x  <= mem_x[rd_ptr];
      alu_y  <= mem_y[rd_ptr];
      alu_s2 <= mem_op[rd_ptr][2];
      alu_s1 <= mem_op[rd_ptr][1];
      alu_s0 <= mem_op[rd_ptr][0];
    end
  end

  // Result capture; unsupported opcodes report zero data with res_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_op    <= '0;
      res_err   <= 1'b0;
    end else if (capture) begin
      res_valid <= 1'b1;
      res_data  <= unsup ? '0 : alu_z;
      res_op    <= {alu_s2, alu_s1, alu_s0};
      res_err   <= unsup;
    end else if (release_res) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU and an
// in-order result scoreboard.
module tb_alu_cmd_sequencer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_x;
  logic [7:0] cmd_y;
  logic [2:0] cmd_op;
  logic [7:0] alu_x;
  logic [7:0] alu_y;
  logic       alu_s2;
  logic       alu_s1;
  logic       alu_s0;
  logic [7:0] alu_z;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [2:0] res_op;
  logic       res_err;
  logic [2:0] count;

  int vectors = 0;
  int miscompares = 0;
  int rx_cnt = 0;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] op;
  } cmd_t;

  cmd_t q[$];

  alu_cmd_sequencer #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_x(cmd_x),
    .cmd_y(cmd_y),
    .cmd_op(cmd_op),
    .alu_x(alu_x),
    .alu_y(alu_y),
    .alu_s2(alu_s2),
    .alu_s1(alu_s1),
    .alu_s0(alu_s0),
    .alu_z(alu_z),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .res_op(res_op),
    .res_err(res_err),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; unsupported codes return junk the DUT must mask.
  function automatic logic [7:0] alu_fn(input logic [7:0] x,
                                        input logic [7:0] y,
                                        input logic [2:0] op);
    case (op)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return ~x;
      3'd3:    return x ^ y;
      3'd4:    return x + y;
      3'd5:    return x - y;
      default: return 8'hA5;
    endcase
  endfunction

  function automatic logic [7:0] exp_data(input cmd_t c);
    return (c.op >= 3'd6) ? 8'h00 : alu_fn(c.x, c.y, c.op);
  endfunction

  always_comb alu_z = alu_fn(alu_x, alu_y, {alu_s2, alu_s1, alu_s0});

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every transfer must match the oldest accepted command,
  // and a pending result must stay stable until taken.
  logic       pv, ptaken, pe;
  logic [7:0] pd;
  logic [2:0] po;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      pv     = 1'b0;
      ptaken = 1'b0;
    end else begin
      if (pv && !ptaken) begin
        chk("hold_valid", res_valid, 1);
        chk("hold_data", res_data, pd);
        chk("hold_op", res_op, po);
        chk("hold_err", res_err, pe);
      end
      if (res_valid && res_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          cmd_t e;
          e = q.pop_front();
          chk("sb_data", res_data, exp_data(e));
          chk("sb_op", res_op, e.op);
          chk("sb_err", res_err, (e.op >= 3'd6));
        end
        rx_cnt++;
      end
      if (cmd_valid && cmd_ready) begin
        cmd_t c;
        c.x  = cmd_x;
        c.y  = cmd_y;
        c.op = cmd_op;
        q.push_back(c);
      end
      pv     = res_valid;
      ptaken = res_valid && res_ready;
      pd     = res_data;
      po     = res_op;
      pe     = res_err;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds cmd_valid until accepted; leaves it high for the caller.
  task automatic send(input logic [7:0] x, input logic [7:0] y,
                      input logic [2:0] op);
    logic cr;
    bit ok;
    cmd_valid = 1'b1;
    cmd_x     = x;
    cmd_y     = y;
    cmd_op    = op;
    ok        = 0;
    for (int i = 0; i < 40; i++) begin
      cr = cmd_ready;
      tick();
      if (cr) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_valid(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (res_valid) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk(name, 0, 1);
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 60; i++) begin
      if (rx_cnt >= n) break;
      tick();
    end
    chk("rx_count", rx_cnt, n);
  endtask

  task automatic one_op(input logic [2:0] op, input logic [7:0] ed,
                        input logic ee);
    send(8'hAA, 8'hCC, op);
    cmd_valid = 1'b0;
    wait_valid("op_timeout");
    chk("op_data", res_data, ed);
    chk("op_err", res_err, ee);
    chk("op_code", res_op, op);
    repeat (2) tick();
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_op    = '0;
    res_ready = 1'b0;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_alu", {alu_x, alu_y, alu_s2, alu_s1, alu_s0}, 0);
    chk("rst_res", {res_data, res_op, res_err}, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Latency: push at edge N, result visible after N+2, not earlier.
    send(8'hAA, 8'hCC, 3'b000);
    cmd_valid = 1'b0;
    chk("lat_n", res_valid, 0);
    tick();
    chk("lat_n1", res_valid, 0);
    tick();
    chk("lat_n2", res_valid, 1);
    chk("lat_data", res_data, 8'h88);
    repeat (2) tick();
    chk("lat_held", res_valid, 1);
    chk("hold_alu_x", alu_x, 8'hAA);
    chk("hold_alu_y", alu_y, 8'hCC);
    res_ready = 1'b1;
    tick();
    chk("lat_release", res_valid, 0);
    tick();
    chk("idle_alu_x", alu_x, 8'hAA);

    // Operation table with literal results.
    one_op(3'b001, 8'hEE, 1'b0);
    one_op(3'b010, 8'h55, 1'b0);
    one_op(3'b011, 8'h66, 1'b0);
    one_op(3'b100, 8'h76, 1'b0);
    one_op(3'b101, 8'hDE, 1'b0);
    one_op(3'b111, 8'h00, 1'b1);
    one_op(3'b110, 8'h00, 1'b1);

    // Backpressure: five fit, the sixth is held until results drain.
    res_ready = 1'b0;
    rx_cnt    = 0;
    for (int i = 0; i < 5; i++) send(8'(i + 1), 8'(3 * i), 3'(i));
    chk("full_ready", cmd_ready, 0);
    chk("full_count", count, 4);
    cmd_x  = 8'h60;
    cmd_y  = 8'h0F;
    cmd_op = 3'b011;
    repeat (3) tick();
    chk("held_ready", cmd_ready, 0);
    chk("held_count", count, 4);
    chk("held_rx", rx_cnt, 0);
    res_ready = 1'b1;
    send(8'h60, 8'h0F, 3'b011);
    cmd_valid = 1'b0;
    wait_rx(6);
    chk("bp_q_empty", q.size(), 0);
    tick();

    // Throughput: continuous push with res_ready high.
    rx_cnt = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(8'(8'h11 * i), 8'(8'h90 + i), 3'(i));
        cmd_valid = 1'b0;
      end
      begin
        wait_valid("tp_first");
        for (int k = 0; k < 7; k++) begin
          tick();
          chk("tp_gap", res_valid, 0);
          tick();
          chk("tp_pulse", res_valid, 1);
        end
      end
    join
    wait_rx(8);
    tick();

    // Reset while DRIVE with three commands still queued.
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(8'(8'hC0 + i), 8'h03, 3'b100);
    cmd_valid = 1'b0;
    chk("pre_rst_count", count, 4);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("drive_count", count, 3);
    chk("drive_valid", res_valid, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_alu", {alu_x, alu_y, alu_s2, alu_s1, alu_s0}, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    tick();
    rst       = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("no_stale_valid", res_valid, 0);
    end
    chk("post_rst_count", count, 0);
    chk("end_q_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
